// File: rtl/ps2_rx.sv
`timescale 1ns / 1ps
// ps2_rx: PS/2 device-to-host receiver.
// Deserialises 11-bit frames (start, 8 data bits LSB first, odd parity, stop).
// PS2Clk and PS2Data are synchronised, and PS2Clk is glitch-filtered.
// Data is sampled on the falling edges of the filtered clock.
// The receiver only observes the bus; it never drives PS2Clk or PS2Data.
// Optional build macro: PS2_RX_DEBUG_EN adds the registered State debug port.
//
// Output strobes: Ready and Error are single-cycle pulses that never assert
// together. Ready means Data has just been updated with a good byte. Error
// means a frame was rejected by the parity, stop or timeout check. There is
// no back-pressure: a strobe is lost if the consumer is not watching in that
// cycle, and Data stays valid until the next good frame.
module ps2_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       PS2Clk,
    input  logic       PS2Data,
    input  logic       Enable,
    output logic [7:0] Data,
    output logic       Ready,
    output logic       Error,
    output logic       Idle
`ifdef PS2_RX_DEBUG_EN
    ,
    output logic [7:0] State
`endif
);

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic [FW-1:0] filt_cnt;
    logic          filt_clk, filt_prev;
    logic          fall;
    logic [7:0]    shift, shift_nxt;
    logic [3:0]    bit_cnt, bit_cnt_nxt;
    logic          par, par_nxt;
    logic [TW-1:0] tmo, tmo_nxt;
    logic          frame_ok, frame_bad, timeout;
    logic          ready_nxt, error_nxt;

    // Two-flop synchronisers for both pad signals; idle bus level is 1.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= PS2Clk;
            clk_s2 <= clk_s1;
            dat_s1 <= PS2Data;
            dat_s2 <= dat_s1;
        end
    end

    // Glitch filter: follow the synchronised clock only after FILTER_LEN
    // consecutive samples that disagree with the current filtered level.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            filt_cnt  <= '0;
            filt_clk  <= 1'b1;
            filt_prev <= 1'b1;
        end else begin
            filt_prev <= filt_clk;
            if (clk_s2 == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_MAX) begin
                filt_clk <= clk_s2;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    assign fall = filt_prev & ~filt_clk;

    // State and datapath registers; the strobes are registered one cycle after the decision.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state   <= S_IDLE;
            shift   <= 8'h00;
            bit_cnt <= 4'd0;
            par     <= 1'b0;
            tmo     <= '0;
            Data    <= 8'h00;
            Ready   <= 1'b0;
            Error   <= 1'b0;
        end else begin
            state   <= state_nxt;
            shift   <= shift_nxt;
            bit_cnt <= bit_cnt_nxt;
            par     <= par_nxt;
            tmo     <= tmo_nxt;
            Ready   <= ready_nxt;
            Error   <= error_nxt;
            if (frame_ok) begin
                Data <= shift;
            end
        end
    end

    // Next-state logic: frame sequencing, timeout and the Enable override.
    always_comb begin
        state_nxt   = state;
        shift_nxt   = shift;
        bit_cnt_nxt = bit_cnt;
        par_nxt     = par;
        tmo_nxt     = tmo;
        frame_ok    = 1'b0;
        frame_bad   = 1'b0;
        timeout     = 1'b0;
        if (!Enable) begin
            // Partial frames are dropped silently while the transmitter owns the bus.
            state_nxt = S_IDLE;
            tmo_nxt   = '0;
        end else if (state == S_IDLE) begin
            tmo_nxt = '0;
            // A falling edge with data 1 is a stray edge and is ignored.
            if (fall && !dat_s2) begin
                state_nxt   = S_DATA;
                bit_cnt_nxt = 4'd0;
            end
        end else if (!fall && tmo == TMO_MAX) begin
            timeout   = 1'b1;
            state_nxt = S_IDLE;
            tmo_nxt   = '0;
        end else if (!fall) begin
            tmo_nxt = tmo + 1'b1;
        end else begin
            tmo_nxt = '0;
            case (state)
                S_DATA: begin
                    shift_nxt   = {dat_s2, shift[7:1]};
                    bit_cnt_nxt = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) begin
                        state_nxt = S_PARITY;
                    end
                end
                S_PARITY: begin
                    par_nxt   = dat_s2;
                    state_nxt = S_STOP;
                end
                S_STOP: begin
                    state_nxt = S_IDLE;
                    if (dat_s2 && ((^shift) ^ par)) begin
                        frame_ok = 1'b1;
                    end else begin
                        frame_bad = 1'b1;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Output decode: strobe values for the next cycle and the Idle flag.
    always_comb begin
        ready_nxt = frame_ok;
        error_nxt = frame_bad | timeout;
        Idle      = (state == S_IDLE);
    end

`ifdef PS2_RX_DEBUG_EN
    // Debug snapshot aligned with the registered strobes.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            State <= 8'h00;
        end else begin
            State <= {error_nxt, ready_nxt, bit_cnt_nxt, state_nxt};
        end
    end
`endif

endmodule
